// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD converter arbiter.
package bcd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_REL} state_t;

  localparam int         BCD_MAX      = 9999;
  localparam logic [7:0] DASH_CODE    = 8'h0F;
  localparam int         CONV_MIN_LAT = 30;

  typedef struct packed {
    logic [1:0]  id;
    logic        ovf;
    logic [31:0] dig;
  } res_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester search starting at rr_ptr; pointer moves past the served id.
module rr_arbiter import bcd_pkg::*; #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  input  logic [1:0]      adv_id,
  output logic [1:0]      sel_id,
  output logic            any_req
);
  logic [1:0] rr_ptr;
  logic [3:0] req_pad;
  logic [2:0] sum;

  assign req_pad = 4'(req);

  // Walk downward so the closest set bit at or after rr_ptr wins.
  always_comb begin
    sel_id  = '0;
    any_req = 1'b0;
    sum     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
      if (req_pad[sum[1:0]]) begin
        any_req = 1'b1;
        sel_id  = sum[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rr_ptr <= '0;
    else if (adv) rr_ptr <= (adv_id >= 2'(NREQ-1)) ? 2'd0 : adv_id + 2'd1;
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one external double-dabble converter between NREQ requesters; results are
// captured after a fixed latency and returned tagged with the requester id.
module bcd_conv_arbiter import bcd_pkg::*; #(
  parameter int         NREQ     = 3,
  parameter int         DATA_W   = 28,
  parameter int         CONV_LAT = 31,
  parameter logic [7:0] DASH     = DASH_CODE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic                   res_valid,
  output logic [1:0]             res_id,
  output logic [31:0]            res_dig,
  output logic                   res_ovf,
  output logic [DATA_W-1:0]      conv_ans,
  output logic                   conv_go,
  input  logic [7:0]             conv_dig0,
  input  logic [7:0]             conv_dig1,
  input  logic [7:0]             conv_dig2,
  input  logic [7:0]             conv_dig3
);
  localparam int CNT_W = $clog2(CONV_LAT + 1);

  if (NREQ < 2 || NREQ > 4 || CONV_LAT < CONV_MIN_LAT) begin : g_param_err
    $error("bcd_conv_arbiter: NREQ must be 2..4 and CONV_LAT >= %0d", CONV_MIN_LAT);
  end

  logic [NREQ-1:0][DATA_W-1:0] data_arr;
  state_t                      state, nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic                        ovf_q, ovf_nxt, ld, capt, any_req;
  logic [1:0]                  id_q, sel_id;
  res_t                        res_q;

  assign data_arr = req_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .adv     (state == S_CAPT),
    .adv_id  (id_q),
    .sel_id  (sel_id),
    .any_req (any_req)
  );

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    ovf_nxt = ovf_q;
    ld      = 1'b0;
    capt    = 1'b0;
    case (state)
      S_IDLE: if (any_req) begin
        ld  = 1'b1;
        nxt = S_LOAD;
      end
      // conv_go stays low here so the converter sees a settled value first
      S_LOAD: if (conv_ans > DATA_W'(BCD_MAX)) begin
        ovf_nxt = 1'b1;
        capt    = 1'b1;
        nxt     = S_CAPT;
      end else begin
        ovf_nxt = 1'b0;
        cnt_nxt = CNT_W'(CONV_LAT - 1);
        nxt     = S_RUN;
      end
      S_RUN: if (cnt == '0) begin
        capt = 1'b1;
        nxt  = S_CAPT;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
      S_CAPT: begin
        cnt_nxt = CNT_W'(1);
        nxt     = S_REL;
      end
      S_REL: if (cnt == '0) nxt = S_IDLE;
             else           cnt_nxt = cnt - 1'b1;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      id_q      <= '0;
      conv_ans  <= '0;
      res_valid <= 1'b0;
      grant     <= '0;
      res_q     <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      ovf_q     <= ovf_nxt;
      res_valid <= capt;
      grant     <= capt ? (NREQ'(1) << id_q) : '0;
      if (ld) begin
        id_q     <= sel_id;
        conv_ans <= data_arr[sel_id];
      end
      if (capt) begin
        res_q.id  <= id_q;
        res_q.ovf <= ovf_nxt;
        res_q.dig <= ovf_nxt ? {4{DASH}} : {conv_dig3, conv_dig2, conv_dig1, conv_dig0};
      end
    end
  end

  assign conv_go = (state == S_RUN) || (state == S_CAPT && !ovf_q);
  assign res_id  = res_q.id;
  assign res_ovf = res_q.ovf;
  assign res_dig = res_q.dig;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Randomized and directed bench for bcd_conv_arbiter with a behavioural converter.
module tb_bcd_conv_arbiter;
  localparam int NREQ   = 3;
  localparam int DATA_W = 28;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [DATA_W-1:0]      vals [NREQ];
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        grant;
  logic                   res_valid, res_ovf, conv_go;
  logic [1:0]             res_id;
  logic [31:0]            res_dig, conv_bcd;
  logic [DATA_W-1:0]      conv_ans;
  logic [7:0]             conv_dig0, conv_dig1, conv_dig2, conv_dig3;
  int                     go_cnt = 0;
  int                     checks = 0, errors = 0;
  int                     rr_ptr_m = 0;

  always #5 clk = ~clk;

  assign req_data = {vals[2], vals[1], vals[0]};

  bcd_conv_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .res_valid(res_valid), .res_id(res_id), .res_dig(res_dig),
    .res_ovf(res_ovf), .conv_ans(conv_ans), .conv_go(conv_go),
    .conv_dig0(conv_dig0), .conv_dig1(conv_dig1),
    .conv_dig2(conv_dig2), .conv_dig3(conv_dig3)
  );

  function automatic logic [31:0] ref_dig(longint v);
    if (v > 9999) return {4{8'h0F}};
    return {8'((v / 1000) % 10), 8'((v / 100) % 10), 8'((v / 10) % 10), 8'(v % 10)};
  endfunction

  // Converter: digits are only valid once conv_go has been high for 30 cycles.
  always @(posedge clk) go_cnt <= conv_go ? go_cnt + 1 : 0;
  assign conv_bcd = (go_cnt >= 30) ? ref_dig(longint'(conv_ans)) : 32'hEEEEEEEE;
  assign {conv_dig3, conv_dig2, conv_dig1, conv_dig0} = conv_bcd;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] pick(logic [NREQ-1:0] m, int p);
    logic [1:0] j;
    for (int k = 0; k < NREQ; k++) begin
      j = 2'((p + k) % NREQ);
      if (m[j]) return j;
    end
    return 2'd0;
  endfunction

  function automatic logic [DATA_W-1:0] rv();
    case ($urandom_range(0, 5))
      0:       return 28'd9999;
      1:       return 28'd10000;
      2:       return 28'($urandom);
      default: return 28'($urandom_range(0, 9999));
    endcase
  endfunction

  task automatic wait_res(output int n, output int g);
    n = 0;
    g = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (conv_go) g++;
      if (res_valid) return;
    end
    chk("res_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_res(string tag, logic [1:0] id, logic [DATA_W-1:0] v);
    chk({tag, "_id"},    32'(res_id),  32'(id));
    chk({tag, "_dig"},   res_dig,      ref_dig(longint'(v)));
    chk({tag, "_ovf"},   32'(res_ovf), 32'(v > 28'd9999));
    chk({tag, "_grant"}, 32'(grant),   32'(3'(1) << id));
  endtask

  // Raise all requesters in m at once (DUT idle) and serve them in model order.
  task automatic serve(logic [NREQ-1:0] m, logic [DATA_W-1:0] a, b, c);
    logic [NREQ-1:0] pend = m;
    logic [1:0]      id;
    logic            first = 1'b1;
    logic            ov;
    int              n, g;
    vals[0] = a; vals[1] = b; vals[2] = c;
    req = m;
    while (pend != '0) begin
      id = pick(pend, rr_ptr_m);
      wait_res(n, g);
      ov = vals[id] > 28'd9999;
      check_res("srv", id, vals[id]);
      if (first) chk("latency", 32'(n), ov ? 32'd2 : 32'd33);
      else       chk("period",  32'(n), ov ? 32'd5 : 32'd36);
      chk("go_cycles", 32'(g), ov ? 32'd0 : 32'd32);
      req[id]  = 1'b0;
      pend[id] = 1'b0;
      rr_ptr_m = (int'(id) + 1) % NREQ;
      first    = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n, g, pulses;
    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < NREQ; i++) vals[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_grant", 32'(grant),     32'd0);
    chk("rst_dig",   res_dig,        32'd0);
    chk("rst_id",    32'(res_id),    32'd0);
    chk("rst_ovf",   32'(res_ovf),   32'd0);
    chk("rst_go",    32'(conv_go),   32'd0);
    chk("rst_ans",   32'(conv_ans),  32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    serve(3'b001, 28'd1234, 28'd0, 28'd0);
    serve(3'b001, 28'd9999, 28'd0, 28'd0);
    serve(3'b001, 28'd0,    28'd0, 28'd0);
    serve(3'b100, 28'd0,    28'd0, 28'd10000);
    serve(3'b111, 28'd5,    28'd42, 28'd777);
    serve(3'b001, 28'd5,    28'd0, 28'd0);

    // requester data changed mid-run; the latched value must be converted
    vals[0] = 28'd1234;
    req     = 3'b001;
    repeat (12) @(negedge clk);
    vals[0] = 28'd4321;
    wait_res(n, g);
    check_res("chg", 2'd0, 28'd1234);
    chk("chg_latency", 32'(n), 32'd21);
    wait_res(n, g);
    check_res("chg_re", 2'd0, 28'd4321);
    chk("chg_period", 32'(n), 32'd36);
    req      = '0;
    rr_ptr_m = 1;
    repeat (4) @(negedge clk);

    // back-to-back from requester 1 with a new value on the re-request
    vals[1] = 28'd300;
    req     = 3'b010;
    wait_res(n, g);
    check_res("b2b_a", 2'd1, 28'd300);
    vals[1] = 28'd8765;
    wait_res(n, g);
    check_res("b2b_b", 2'd1, 28'd8765);
    chk("b2b_period", 32'(n), 32'd36);
    chk("b2b_golow",  32'((n - g) >= 3), 32'd1);
    req      = '0;
    rr_ptr_m = 2;
    repeat (4) @(negedge clk);

    // reset in the middle of a conversion
    vals[0] = 28'd1234;
    req     = 3'b001;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_go",    32'(conv_go),   32'd0);
    chk("mid_ans",   32'(conv_ans),  32'd0);
    chk("mid_dig",   res_dig,        32'd0);
    chk("mid_id",    32'(res_id),    32'd0);
    chk("mid_valid", 32'(res_valid), 32'd0);
    chk("mid_grant", 32'(grant),     32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    rr_ptr_m = 0;
    pulses   = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    chk("mid_no_result", 32'(pulses), 32'd0);
    serve(3'b001, 28'd56, 28'd0, 28'd0);

    for (int it = 0; it < 20; it++)
      serve(3'($urandom_range(1, 7)), rv(), rv(), rv());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
